// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared constants and types for the pipeline hazard unit
package hazard_unit_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // {file=0, addr=0} is the hardwired zero register
    localparam int ZERO_REG_ID = 0;

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    function automatic logic is_load_opcode(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-source producer comparator yielding {m1,m2,m3,load_hit}
module hazard_src_match
    import hazard_unit_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int FILE_W   = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     check_en,
    input  logic [FILE_W+ADDR_W-1:0] src,
    input  logic                     ex_valid,
    input  logic                     ex_regwrite,
    input  logic                     ex_is_load,
    input  logic [FILE_W+ADDR_W-1:0] ex_rw,
    input  logic                     mem_valid,
    input  logic                     mem_regwrite,
    input  logic                     mem_is_load,
    input  logic [FILE_W+ADDR_W-1:0] mem_rw,
    input  logic                     wb_regwrite,
    input  logic [FILE_W+ADDR_W-1:0] wb_rw,
    output logic [3:0]               hit
);

    localparam int SW = FILE_W + ADDR_W;

    logic live;
    logic m1;
    logic m2;
    logic m3;
    logic load_hit;

    always_comb begin
        live     = check_en && (src != SW'(ZERO_REG_ID));
        m1       = live && ex_valid && ex_regwrite && (ex_rw == src);
        m2       = live && mem_valid && mem_regwrite && (mem_rw == src);
        m3       = live && wb_regwrite && (wb_rw == src);
        // with a two-cycle load the value is still unavailable one stage later
        load_hit = (m1 && ex_is_load) || ((LOAD_LAT > 1) && m2 && mem_is_load);
        hit      = {m1, m2, m3, load_hit};
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - hazard detection, forwarding selects and load-use stall control
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int FILE_W   = 2,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             id_valid,
    input  logic [NUM_SRC*(FILE_W+ADDR_W)-1:0] id_src,
    input  logic [NUM_SRC-1:0]               id_src_en,
    input  logic                             ex_valid,
    input  logic                             ex_regwrite,
    input  logic                             ex_is_load,
    input  logic [FILE_W+ADDR_W-1:0]         ex_rw,
    input  logic                             mem_valid,
    input  logic                             mem_regwrite,
    input  logic [FILE_W+ADDR_W-1:0]         mem_rw,
    input  logic                             wb_regwrite,
    input  logic [FILE_W+ADDR_W-1:0]         wb_rw,
    input  logic                             flush,
    output logic                             stall,
    output logic                             bubble,
    output logic [2*NUM_SRC-1:0]             ex_fwd_sel,
    output logic [NUM_SRC-1:0]               id_bypass,
    output logic [CNT_W-1:0]                 stall_cycles
);

    localparam int SW  = FILE_W + ADDR_W;
    localparam int LCW = 2;

    logic [NUM_SRC-1:0]   m1_v;
    logic [NUM_SRC-1:0]   m2_v;
    logic [NUM_SRC-1:0]   m3_v;
    logic [NUM_SRC-1:0]   lh_v;

    hz_state_e            state_q, state_d;
    logic [LCW-1:0]       cnt_q, cnt_d;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
    logic                 mem_is_load_q, mem_is_load_d;
    logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;

    logic                 hazard;
    logic                 stall_core;
    logic                 bubble_core;
    logic [2*NUM_SRC-1:0] codes;
    logic [NUM_SRC-1:0]   bypass_core;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [3:0] hit;

        hazard_src_match #(
            .ADDR_W   (ADDR_W),
            .FILE_W   (FILE_W),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .check_en     (id_valid & id_src_en[g]),
            .src          (id_src[g*SW +: SW]),
            .ex_valid     (ex_valid),
            .ex_regwrite  (ex_regwrite),
            .ex_is_load   (ex_is_load),
            .ex_rw        (ex_rw),
            .mem_valid    (mem_valid),
            .mem_regwrite (mem_regwrite),
            .mem_is_load  (mem_is_load_q),
            .mem_rw       (mem_rw),
            .wb_regwrite  (wb_regwrite),
            .wb_rw        (wb_rw),
            .hit          (hit)
        );

        assign {m1_v[g], m2_v[g], m3_v[g], lh_v[g]} = hit;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_core  = 1'b0;
        bubble_core = 1'b0;
        hazard      = |lh_v;
        if (flush) begin
            bubble_core = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        stall_core  = 1'b1;
                        bubble_core = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = LCW'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    stall_core  = 1'b1;
                    bubble_core = 1'b1;
                    cnt_d       = cnt_q - LCW'(1);
                    if (cnt_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        codes       = '0;
        bypass_core = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m1_v[i]) begin
                codes[2*i +: 2] = FWD_EXMEM;
            end else if (m2_v[i]) begin
                codes[2*i +: 2] = FWD_MEMWB;
            end else begin
                codes[2*i +: 2] = FWD_NONE;
                bypass_core[i]  = m3_v[i];
            end
        end
    end

    always_comb begin
        if (bubble_core) begin
            fwd_sel_d = '0;
        end else if (!stall_core) begin
            fwd_sel_d = codes;
        end else begin
            fwd_sel_d = fwd_sel_q;
        end
        // EX always advances (a bubble replaces it on stall), so MEM's load flag follows EX
        mem_is_load_d  = ex_valid & ex_is_load;
        stall_cycles_d = stall_cycles_q;
        if (stall_core && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fwd_sel_q      <= '0;
            mem_is_load_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fwd_sel_q      <= fwd_sel_d;
            mem_is_load_q  <= mem_is_load_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = stall_core & ~reset;
    assign bubble       = bubble_core & ~reset;
    assign id_bypass    = bypass_core & {NUM_SRC{~reset}};
    assign ex_fwd_sel   = fwd_sel_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed and random checks of hazard_unit against a behavioural model
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [13:0] id_src;
    logic [1:0]  id_src_en;
    logic        ex_valid, ex_regwrite, ex_is_load;
    logic [6:0]  ex_rw;
    logic        mem_valid, mem_regwrite;
    logic [6:0]  mem_rw;
    logic        wb_regwrite;
    logic [6:0]  wb_rw;
    logic        flush;

    logic        stall1, bubble1, stall2, bubble2, stall3, bubble3;
    logic [3:0]  fsel1, fsel2, fsel3;
    logic [1:0]  byp1, byp2, byp3;
    logic [31:0] cyc1, cyc2;
    logic [3:0]  cyc3;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: config 0 = LOAD_LAT 1, 1 = LOAD_LAT 2, 2 = LOAD_LAT 1 with 4-bit counter
    int      lat [3] = '{1, 2, 1};
    longint  cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    int      m_left[3];
    int      m_fsel[3];
    longint  m_cnt[3];
    bit      m_memload;
    bit      e_stall[3], e_bub[3], e_haz[3];
    int      e_code[2];

    always #5 clock = ~clock;

    hazard_unit #(.LOAD_LAT(1), .CNT_W(32)) dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rw(ex_rw),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rw(mem_rw),
        .wb_regwrite(wb_regwrite), .wb_rw(wb_rw), .flush(flush),
        .stall(stall1), .bubble(bubble1), .ex_fwd_sel(fsel1), .id_bypass(byp1), .stall_cycles(cyc1));

    hazard_unit #(.LOAD_LAT(2), .CNT_W(32)) dut2 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rw(ex_rw),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rw(mem_rw),
        .wb_regwrite(wb_regwrite), .wb_rw(wb_rw), .flush(flush),
        .stall(stall2), .bubble(bubble2), .ex_fwd_sel(fsel2), .id_bypass(byp2), .stall_cycles(cyc2));

    hazard_unit #(.LOAD_LAT(1), .CNT_W(4)) dut3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rw(ex_rw),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rw(mem_rw),
        .wb_regwrite(wb_regwrite), .wb_rw(wb_rw), .flush(flush),
        .stall(stall3), .bubble(bubble3), .ex_fwd_sel(fsel3), .id_bypass(byp3), .stall_cycles(cyc3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0;
            m_fsel[k] = 0;
            m_cnt[k]  = 0;
        end
        m_memload = 1'b0;
    endtask

    // wait for the falling edge, predict combinational outputs and compare all three DUTs
    task automatic sample_check();
        bit lu1, lu2;
        bit e_byp[2];
        logic [6:0] src;
        bit live, h1, h2, h3;
        logic        os, ob;
        logic [3:0]  of;
        logic [1:0]  oy;
        logic [31:0] oc;
        @(negedge clock);
        if (reset) clear_model();
        lu1 = 0;
        lu2 = 0;
        for (int s = 0; s < 2; s++) begin
            src  = id_src[s*7 +: 7];
            live = id_valid && id_src_en[s] && (src != 7'd0);
            h1   = live && ex_valid && ex_regwrite && (ex_rw == src);
            h2   = live && mem_valid && mem_regwrite && (mem_rw == src);
            h3   = live && wb_regwrite && (wb_rw == src);
            e_code[s] = h1 ? 1 : (h2 ? 2 : 0);
            e_byp[s]  = !h1 && !h2 && h3 && !reset;
            if (h1 && ex_is_load) lu1 = 1;
            if (h2 && m_memload) lu2 = 1;
        end
        for (int k = 0; k < 3; k++) begin
            e_haz[k] = lu1 || (lat[k] == 2 && lu2);
            if (reset)               begin e_stall[k] = 0; e_bub[k] = 0; end
            else if (flush)          begin e_stall[k] = 0; e_bub[k] = 1; end
            else if (m_left[k] > 0)  begin e_stall[k] = 1; e_bub[k] = 1; end
            else if (e_haz[k])       begin e_stall[k] = 1; e_bub[k] = 1; end
            else                     begin e_stall[k] = 0; e_bub[k] = 0; end
            case (k)
                0:       begin os = stall1; ob = bubble1; of = fsel1; oy = byp1; oc = cyc1; end
                1:       begin os = stall2; ob = bubble2; of = fsel2; oy = byp2; oc = cyc2; end
                default: begin os = stall3; ob = bubble3; of = fsel3; oy = byp3; oc = {28'd0, cyc3}; end
            endcase
            chk($sformatf("d%0d.stall", k), {31'd0, os}, {31'd0, e_stall[k]});
            chk($sformatf("d%0d.bubble", k), {31'd0, ob}, {31'd0, e_bub[k]});
            chk($sformatf("d%0d.fwd_sel", k), {28'd0, of}, 32'(m_fsel[k]));
            chk($sformatf("d%0d.bypass", k), {30'd0, oy}, {30'd0, e_byp[1], e_byp[0]});
            chk($sformatf("d%0d.cycles", k), oc, 32'(m_cnt[k]));
        end
    endtask

    task automatic advance();
        @(posedge clock);
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (e_bub[k])        m_fsel[k] = 0;
                else if (!e_stall[k]) m_fsel[k] = e_code[1] * 4 + e_code[0];
                if (flush)           m_left[k] = 0;
                else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                else if (e_haz[k])   m_left[k] = lat[k] - 1;
                if (e_stall[k] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
            m_memload = ex_valid && ex_is_load;
        end
        #1;
    endtask

    task automatic cycle();
        sample_check();
        advance();
    endtask

    task automatic set_idle();
        id_valid = 0; id_src = '0; id_src_en = '0;
        ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_rw = '0;
        mem_valid = 0; mem_regwrite = 0; mem_rw = '0;
        wb_regwrite = 0; wb_rw = '0; flush = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic load_r5_hazard();
        set_idle();
        ex_valid = 1; ex_regwrite = 1; ex_is_load = is_load_opcode(OP_LW); ex_rw = 7'd5;
        id_valid = 1; id_src_en = 2'b10; id_src = {7'd5, 7'd0};
    endtask

    function automatic logic [6:0] rand_id();
        logic [6:0] r;
        r[6:5] = 2'($urandom_range(0, 1));
        r[4:0] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        logic [5:0] op;
        reset = 1;
        set_idle();
        clear_model();
        cycle();
        chk("reset.cycles", cyc1, 32'd0);
        chk("reset.fwd_sel", {28'd0, fsel2}, 32'd0);
        reset = 0;

        // ALU producer in EX forwards from EX/MEM
        ex_valid = 1; ex_regwrite = 1; ex_rw = 7'd3;
        id_valid = 1; id_src_en = 2'b01; id_src = {7'd0, 7'd3};
        sample_check();
        chk("alu.no_stall", {31'd0, stall1}, 32'd0);
        advance();
        chk("alu.fwd01", {30'd0, fsel1[1:0]}, {30'd0, FWD_EXMEM});

        // load-use on source 1
        do_reset();
        load_r5_hazard();
        sample_check();
        chk("lw.stall1", {31'd0, stall1}, 32'd1);
        chk("lw.bubble1", {31'd0, bubble1}, 32'd1);
        advance();
        set_idle();
        mem_valid = 1; mem_regwrite = 1; mem_rw = 7'd5;
        id_valid = 1; id_src_en = 2'b10; id_src = {7'd5, 7'd0};
        sample_check();
        chk("lw.release1", {31'd0, stall1}, 32'd0);
        chk("lw.hold2", {31'd0, stall2}, 32'd1);
        advance();
        chk("lw.fwd10", {30'd0, fsel1[3:2]}, {30'd0, FWD_MEMWB});
        set_idle();
        wb_regwrite = 1; wb_rw = 7'd5;
        id_valid = 1; id_src_en = 2'b10; id_src = {7'd5, 7'd0};
        sample_check();
        chk("lw.release2", {31'd0, stall2}, 32'd0);
        chk("lw.bypass2", {31'd0, byp2[1]}, 32'd1);
        chk("lw.cycles2", cyc2, 32'd2);
        chk("lw.cycles1", cyc1, 32'd1);
        advance();

        // nearest producer wins
        set_idle();
        ex_valid = 1; ex_regwrite = 1; ex_rw = 7'd7;
        mem_valid = 1; mem_regwrite = 1; mem_rw = 7'd7;
        id_valid = 1; id_src_en = 2'b01; id_src = {7'd0, 7'd7};
        cycle();
        chk("nearest.fwd01", {30'd0, fsel1[1:0]}, {30'd0, FWD_EXMEM});

        // zero register never matches, even against a load
        set_idle();
        ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rw = 7'd0;
        id_valid = 1; id_src_en = 2'b01; id_src = '0;
        sample_check();
        chk("zero.no_stall", {31'd0, stall1}, 32'd0);
        advance();
        chk("zero.fwd00", {28'd0, fsel1}, 32'd0);

        // FP f4 against integer r4
        set_idle();
        ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rw = {2'd1, 5'd4};
        id_valid = 1; id_src_en = 2'b01; id_src = {7'd0, 2'd0, 5'd4};
        sample_check();
        chk("file.no_stall", {31'd0, stall2}, 32'd0);
        advance();

        // flush beats load-use hazard
        load_r5_hazard();
        flush = 1;
        sample_check();
        chk("flush.stall", {31'd0, stall1}, 32'd0);
        chk("flush.bubble", {31'd0, bubble1}, 32'd1);
        advance();
        set_idle();
        sample_check();
        chk("flush.idle2", {31'd0, stall2}, 32'd0);
        advance();

        // reset mid-STALL
        load_r5_hazard();
        cycle();
        set_idle();
        reset = 1;
        #1;
        sample_check();
        chk("rst.stall2", {31'd0, stall2}, 32'd0);
        chk("rst.cycles2", cyc2, 32'd0);
        advance();
        reset = 0;

        // counter saturation
        do_reset();
        load_r5_hazard();
        repeat (20) cycle();
        chk("sat.cycles3", {28'd0, cyc3}, 32'd15);
        chk("sat.cycles1", cyc1, 32'd20);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_src       = {rand_id(), rand_id()};
            id_src_en    = 2'($urandom_range(0, 3));
            ex_valid     = $urandom_range(0, 1) == 1;
            ex_regwrite  = $urandom_range(0, 3) != 0;
            op           = ($urandom_range(0, 1) == 1) ? 6'(32 + $urandom_range(0, 5)) : 6'd0;
            ex_is_load   = is_load_opcode(op);
            ex_rw        = rand_id();
            mem_valid    = $urandom_range(0, 1) == 1;
            mem_regwrite = $urandom_range(0, 3) != 0;
            mem_rw       = rand_id();
            wb_regwrite  = $urandom_range(0, 1) == 1;
            wb_rw        = rand_id();
            flush        = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
